// File: rtl/cordic_ln_if.sv
// Handshake bundle for the iterative natural-log unit.
//   in_valid/in_ready/x_in    : operand channel, producer -> unit
//   out_valid/out_ready       : result channel, unit -> consumer
//   ln_out/err                : result payload, valid while out_valid is high
// master: the side that supplies operands and retires results.
// slave : the log unit itself.
interface cordic_ln_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] ln_out;
  logic             err;

  modport master (
    output in_valid, x_in, out_ready,
    input  in_ready, out_valid, ln_out, err
  );

  modport slave (
    input  in_valid, x_in, out_ready,
    output in_ready, out_valid, ln_out, err
  );
endinterface

// File: rtl/cordic_ln.sv
// Iterative natural logarithm by multiplicative normalization.
// A running product p starts at 1.0 and is greedily multiplied by (1 + 2^-i)
// whenever that keeps it at or below x; every accepted factor adds the matching
// ln(1 + 2^-i) constant into acc. One index i is tried per clock.
// Operand and result are unsigned Q2.30; legal operands lie in [1.0, 2.0).
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset, aborts any computation in flight
//   io  : cordic_ln_if slave (in_valid/in_ready/x_in, out_valid/out_ready,
//         ln_out, err)
module cordic_ln_iter #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 30,
  parameter int ITER  = 30
) (
  input  logic         clk,
  input  logic         rst,
  cordic_ln_if.slave   io
);

  localparam int IW = $clog2(ITER + 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1) << FRAC;
  localparam logic [IW-1:0]    I_FIRST = IW'(1);
  localparam logic [IW-1:0]    I_LAST  = IW'(ITER);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // round(ln(1 + 2^-idx) * 2^30); entries past 17 are plain powers of two
  // because the second-order term is already below half an LSB.
  function automatic logic [31:0] ln_term(input logic [4:0] idx);
    logic [31:0] t;
    case (idx)
      5'd1:    t = 32'd435364845;
      5'd2:    t = 32'd239598564;
      5'd3:    t = 32'd126468572;
      5'd4:    t = 32'd65095192;
      5'd5:    t = 32'd33040817;
      5'd6:    t = 32'd16647494;
      5'd7:    t = 32'd8356010;
      5'd8:    t = 32'd4186133;
      5'd9:    t = 32'd2095107;
      5'd10:   t = 32'd1048064;
      5'd11:   t = 32'd524160;
      5'd12:   t = 32'd262112;
      5'd13:   t = 32'd131064;
      5'd14:   t = 32'd65534;
      5'd15:   t = 32'd32768;
      5'd16:   t = 32'd16384;
      5'd17:   t = 32'd8192;
      5'd18:   t = 32'd4096;
      5'd19:   t = 32'd2048;
      5'd20:   t = 32'd1024;
      5'd21:   t = 32'd512;
      5'd22:   t = 32'd256;
      5'd23:   t = 32'd128;
      5'd24:   t = 32'd64;
      5'd25:   t = 32'd32;
      5'd26:   t = 32'd16;
      5'd27:   t = 32'd8;
      5'd28:   t = 32'd4;
      5'd29:   t = 32'd2;
      5'd30:   t = 32'd1;
      default: t = 32'd0;
    endcase
    return t;
  endfunction

  logic [1:0]       state;
  logic [WIDTH-1:0] x_reg;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] acc;
  logic [IW-1:0]    i;
  logic             out_valid_q;
  logic [WIDTH-1:0] ln_out_q;
  logic             err_q;

  logic [WIDTH-1:0] cand;
  logic             take;
  logic [WIDTH-1:0] acc_next;

  assign io.in_ready  = (state == S_IDLE);
  assign io.out_valid = out_valid_q;
  assign io.ln_out    = ln_out_q;
  assign io.err       = err_q;

  // Candidate product stays below 3.0 for p < 2.0, so Q2.30 cannot overflow.
  always_comb begin
    cand     = p + (p >> i);
    take     = (cand <= x_reg);
    acc_next = acc;
    if (take) begin
      acc_next = acc + WIDTH'(ln_term(5'(i)));
    end
  end

  // ---- iteration register stage ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      x_reg       <= '0;
      p           <= '0;
      acc         <= '0;
      i           <= '0;
      out_valid_q <= 1'b0;
      ln_out_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (io.in_valid) begin
            x_reg <= io.x_in;
            p     <= ONE;
            acc   <= '0;
            i     <= I_FIRST;
            if (io.x_in[WIDTH-1 -: 2] != 2'b01) begin
              err_q       <= 1'b1;
              ln_out_q    <= '0;
              out_valid_q <= 1'b1;
              state       <= S_DONE;
            end else begin
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (take) begin
            p <= cand;
          end
          acc <= acc_next;
          if (i == I_LAST) begin
            ln_out_q    <= acc_next;
            err_q       <= 1'b0;
            out_valid_q <= 1'b1;
            state       <= S_DONE;
          end else begin
            i <= i + 1'b1;
          end
        end
        S_DONE: begin
          // Result holds until retired; the cycle after retire is IDLE,
          // so a waiting producer sees a one-cycle bubble.
          if (io.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: begin
          state       <= S_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_ln_iter.sv
module tb_cordic_ln_iter;

  localparam int W    = 32;
  localparam int ITER = 30;

  localparam logic [31:0] T1 = 32'd435364845;
  localparam logic [31:0] T2 = 32'd239598564;

  logic clk = 1'b0;
  logic rst = 1'b1;

  cordic_ln_if #(.WIDTH(W)) bus ();

  cordic_ln_iter #(.WIDTH(W), .FRAC(30), .ITER(ITER)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errs   = 0;

  typedef struct {
    logic [31:0] x;
    logic [31:0] ln;
    logic        e;
    int          lat;
    int          tol;
    string       name;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input longint act, input longint exp, input longint tol);
    checks++;
    if ((act - exp) > tol || (exp - act) > tol) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", name, act, exp, tol);
    end
  endtask

  // Accepts x on a clean handshake and waits (bounded) for the result.
  // lat counts negedge samples after the accept edge; 0 means timeout.
  task automatic run_op(input logic [31:0] x, output int lat,
                        output logic [31:0] ln, output logic e);
    int w;
    w = 0;
    @(negedge clk);
    while (!bus.in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    bus.x_in     = x;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        lat = k;
        break;
      end
    end
    ln = bus.ln_out;
    e  = bus.err;
  endtask

  task automatic retire();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  initial begin
    int          lat;
    logic [31:0] ln;
    logic        e;

    vecs[0]  = '{32'h4000_0000, 32'd0,         1'b0, ITER+1, 0,  "one"};
    vecs[1]  = '{32'h6000_0000, T1,            1'b0, ITER+1, 1,  "x1p5"};
    vecs[2]  = '{32'h5000_0000, T2,            1'b0, ITER+1, 1,  "x1p25"};
    vecs[3]  = '{32'h4800_0000, 32'd126468572, 1'b0, ITER+1, 1,  "x1p125"};
    vecs[4]  = '{32'h4400_0000, 32'd65095192,  1'b0, ITER+1, 1,  "x1p0625"};
    vecs[5]  = '{32'h7800_0000, 32'd674963409, 1'b0, ITER+1, 1,  "x1p875"};
    vecs[6]  = '{32'h7FFF_FFFF, 32'd744261118, 1'b0, ITER+1, 16, "near_two"};
    vecs[7]  = '{32'h3FFF_FFFF, 32'd0,         1'b1, 1,      0,  "below_one"};
    vecs[8]  = '{32'h8000_0000, 32'd0,         1'b1, 1,      0,  "two"};
    vecs[9]  = '{32'hFFFF_FFFF, 32'd0,         1'b1, 1,      0,  "all_ones"};
    vecs[10] = '{32'h0000_0000, 32'd0,         1'b1, 1,      0,  "zero"};

    bus.in_valid  = 1'b0;
    bus.x_in      = '0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_in_ready",  bus.in_ready,  1, 0);
    chk("rst_out_valid", bus.out_valid, 0, 0);
    chk("rst_ln_out",    bus.ln_out,    0, 0);
    chk("rst_err",       bus.err,       0, 0);

    for (int v = 0; v < 11; v++) begin
      run_op(vecs[v].x, lat, ln, e);
      chk({vecs[v].name, "_lat"}, lat, vecs[v].lat, 0);
      chk({vecs[v].name, "_ln"},  ln,  vecs[v].ln,  vecs[v].tol);
      chk({vecs[v].name, "_err"}, e,   vecs[v].e,   0);
      chk({vecs[v].name, "_busy"}, bus.in_ready, 0, 0);
      retire();
      @(negedge clk);
      chk({vecs[v].name, "_idle"}, bus.in_ready, 1, 0);
    end

    // Stall in DONE with competing operand pulses.
    run_op(32'h6000_0000, lat, ln, e);
    chk("stall_lat", lat, ITER+1, 0);
    bus.x_in     = 32'h3FFF_FFFF;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("stall_valid", bus.out_valid, 1, 0);
      chk("stall_ln",    bus.ln_out,    T1, 1);
      chk("stall_err",   bus.err,       0, 0);
      chk("stall_ready", bus.in_ready,  0, 0);
    end
    bus.in_valid = 1'b0;
    retire();
    @(negedge clk);
    chk("stall_idle_ready", bus.in_ready,  1, 0);
    chk("stall_idle_valid", bus.out_valid, 0, 0);

    // Operand pulses during RUN must not disturb the computation.
    @(negedge clk);
    bus.x_in     = 32'h5000_0000;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      bus.x_in     = 32'h7FFF_FFFF;
      bus.in_valid = 1'b1;
      chk("run_ready", bus.in_ready, 0, 0);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 100; k++) begin
      if (bus.out_valid) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    chk("run_pulse_seen", lat > 0, 1, 0);
    chk("run_pulse_ln",   bus.ln_out, T2, 1);
    chk("run_pulse_err",  bus.err,    0, 0);
    retire();

    // Reset during iteration i=12 aborts without presenting a result.
    @(negedge clk);
    bus.x_in     = 32'h6000_0000;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    chk("mid_valid_pre", bus.out_valid, 0, 0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready", bus.in_ready,  1, 0);
    chk("mid_rst_valid", bus.out_valid, 0, 0);
    chk("mid_rst_ln",    bus.ln_out,    0, 0);
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid) break;
    end
    chk("mid_rst_no_result", bus.out_valid, 0, 0);

    run_op(32'h6000_0000, lat, ln, e);
    chk("post_rst_lat", lat, ITER+1, 0);
    chk("post_rst_ln",  ln,  T1, 1);
    chk("post_rst_err", e,   0, 0);
    retire();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
